// File: rtl/uart_reg_loader.sv
// Assembles {index, 4 data bytes MSB-first} UART frames into single-cycle register-file writes.
// Strobe lands the cycle after the 4th data byte and yields to core_reg_write; RX bytes are dropped (overrun) while a write is pending.
module uart_reg_loader #(
  parameter int               CNT_W          = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load_enable,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_core_reg_write,
  output logic        o_UART_write_enable,
  output logic [4:0]  o_rw,
  output logic [31:0] o_write_data,
  output logic        o_busy,
  output logic        o_load_done,
  output logic [5:0]  o_word_count,
  output logic        o_timeout_err,
  output logic        o_overrun_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_timer;
  logic [4:0]       r_rw;
  logic [31:0]      r_write_data;
  logic             r_load_done;
  logic [5:0]       r_word_count;
  logic             r_timeout_err;
  logic             r_overrun_err;

  logic w_accept_idx;
  logic w_accept_end;
  logic w_shift;
  logic w_timeout;
  logic w_strobe;
  logic w_overrun;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept_idx = 1'b0;
    w_accept_end = 1'b0;
    w_shift      = 1'b0;
    w_timeout    = 1'b0;
    w_strobe     = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid && i_load_enable && !r_load_done) begin
          if (i_rx_data[7]) begin
            w_accept_end = 1'b1;
          end else begin
            w_accept_idx = 1'b1;
            w_next       = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (!i_load_enable) begin
          w_next = S_IDLE;
        end else if (i_rx_valid) begin
          w_shift = 1'b1;
          if (r_byte_cnt == 2'd3) w_next = S_WRITE;
        end else if (r_timer == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!i_load_enable) begin
          w_next = S_IDLE;
        end else begin
          w_overrun = i_rx_valid;
          // Strobe is combinational on core_reg_write so the two writers can never overlap.
          if (!i_core_reg_write && !i_reset) begin
            w_strobe = 1'b1;
            w_next   = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_byte_cnt    <= 2'd0;
      r_timer       <= '0;
      r_rw          <= 5'd0;
      r_write_data  <= 32'd0;
      r_load_done   <= 1'b0;
      r_word_count  <= 6'd0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      r_overrun_err <= w_overrun;
      if (w_accept_end) r_load_done <= 1'b1;
      if (w_accept_idx) begin
        r_rw       <= i_rx_data[4:0];
        r_byte_cnt <= 2'd0;
        r_timer    <= '0;
      end
      if (w_shift) begin
        r_write_data <= {r_write_data[23:0], i_rx_data};
        r_byte_cnt   <= r_byte_cnt + 2'd1;
        r_timer      <= '0;
      end else if (r_state == S_DATA) begin
        r_timer <= r_timer + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_strobe && (r_word_count != 6'd63)) r_word_count <= r_word_count + 6'd1;
    end
  end

  assign o_UART_write_enable = w_strobe;
  assign o_rw                = r_rw;
  assign o_write_data        = r_write_data;
  assign o_busy              = (r_state != S_IDLE);
  assign o_load_done         = r_load_done;
  assign o_word_count        = r_word_count;
  assign o_timeout_err       = r_timeout_err;
  assign o_overrun_err       = r_overrun_err;

endmodule
